// File: rtl/mult_array_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mult_array_arbiter
// Brief    : Round-robin sharing of one pipelined multiplier array between
//            NUM_REQ requesters, with id tags tracked to steer results home.
// Revision : 1.0
// ============================================================================
module mult_array_arbiter #(
    parameter int NUM_REQ      = 6,
    parameter int LANES        = 6,
    parameter int WIDTH        = 36,
    parameter int MULT_LATENCY = 4
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             en,
    input  logic [NUM_REQ-1:0]               req,
    input  logic [NUM_REQ*LANES*WIDTH-1:0]   req_dataa,
    input  logic [NUM_REQ*LANES*WIDTH-1:0]   req_datab,
    output logic [NUM_REQ-1:0]               gnt,
    output logic [NUM_REQ-1:0]               rsp_valid,
    output logic [LANES*WIDTH-1:0]           rsp_result,
    output logic [LANES*WIDTH-1:0]           array_mult_dataa,
    output logic [LANES*WIDTH-1:0]           array_mult_datab,
    input  logic [LANES*WIDTH-1:0]           array_mult_result,
    output logic                             busy
);

    localparam int c_ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int c_SW   = c_ID_W + 1;
    localparam int c_LW   = LANES * WIDTH;

    logic [c_ID_W-1:0]   r_rr_ptr;
    logic [c_LW-1:0]     r_dataa;
    logic [c_LW-1:0]     r_datab;
    // Index 0 is aligned with the operand register; index MULT_LATENCY with the result.
    logic [MULT_LATENCY:0] r_tag_vld;
    logic [c_ID_W-1:0]   r_tag_id [0:MULT_LATENCY];

    logic [NUM_REQ-1:0]  w_gnt;
    logic                w_gnt_any;
    logic [c_ID_W-1:0]   w_gnt_id;
    logic [c_SW-1:0]     w_scan;
    logic [c_LW-1:0]     w_sel_a;
    logic [c_LW-1:0]     w_sel_b;
    logic [c_ID_W-1:0]   w_next_ptr;

    always_comb begin
        w_gnt     = '0;
        w_gnt_any = 1'b0;
        w_gnt_id  = '0;
        w_scan    = '0;
        if (en) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                w_scan = {1'b0, r_rr_ptr} + c_SW'(k);
                if (w_scan >= c_SW'(NUM_REQ)) begin
                    w_scan = w_scan - c_SW'(NUM_REQ);
                end
                if (!w_gnt_any && req[w_scan]) begin
                    w_gnt_any = 1'b1;
                    w_gnt_id  = w_scan[c_ID_W-1:0];
                end
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            w_gnt[i] = w_gnt_any && (w_gnt_id == c_ID_W'(i));
        end
    end

    always_comb begin
        w_sel_a = '0;
        w_sel_b = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_gnt[i]) begin
                w_sel_a = req_dataa[i*c_LW +: c_LW];
                w_sel_b = req_datab[i*c_LW +: c_LW];
            end
        end
    end

    assign w_next_ptr = (w_gnt_id == c_ID_W'(NUM_REQ-1)) ? '0 : w_gnt_id + c_ID_W'(1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rr_ptr  <= '0;
            r_dataa   <= '0;
            r_datab   <= '0;
            r_tag_vld <= '0;
            for (int s = 0; s <= MULT_LATENCY; s++) begin
                r_tag_id[s] <= '0;
            end
        end else begin
            if (w_gnt_any) begin
                r_dataa  <= w_sel_a;
                r_datab  <= w_sel_b;
                r_rr_ptr <= w_next_ptr;
            end
            // Tracker advances every cycle so in-flight ops drain even with en=0.
            r_tag_vld   <= {r_tag_vld[MULT_LATENCY-1:0], w_gnt_any};
            r_tag_id[0] <= w_gnt_id;
            for (int s = 1; s <= MULT_LATENCY; s++) begin
                r_tag_id[s] <= r_tag_id[s-1];
            end
        end
    end

    always_comb begin
        rsp_valid = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            rsp_valid[i] = r_tag_vld[MULT_LATENCY] && (r_tag_id[MULT_LATENCY] == c_ID_W'(i));
        end
    end

    assign gnt              = w_gnt;
    assign rsp_result       = array_mult_result;
    assign array_mult_dataa = r_dataa;
    assign array_mult_datab = r_datab;
    assign busy             = |r_tag_vld;

endmodule
`default_nettype wire

// File: tb/tb_mult_array_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mult_array_arbiter
// Brief    : Scoreboard bench for mult_array_arbiter with a multiplier model.
// Revision : 1.0
// ============================================================================
module tb_mult_array_arbiter;

    localparam int NUM_REQ = 6;
    localparam int LANES   = 6;
    localparam int WIDTH   = 36;
    localparam int L       = 4;
    localparam int LW      = LANES * WIDTH;

    logic                        clk = 1'b0;
    logic                        rst = 1'b0;
    logic                        en  = 1'b0;
    logic [NUM_REQ-1:0]          req = '0;
    logic [NUM_REQ*LW-1:0]       req_dataa = '0;
    logic [NUM_REQ*LW-1:0]       req_datab = '0;
    logic [NUM_REQ-1:0]          gnt;
    logic [NUM_REQ-1:0]          rsp_valid;
    logic [LW-1:0]               rsp_result;
    logic [LW-1:0]               array_mult_dataa;
    logic [LW-1:0]               array_mult_datab;
    logic [LW-1:0]               array_mult_result;
    logic                        busy;

    mult_array_arbiter #(
        .NUM_REQ(NUM_REQ), .LANES(LANES), .WIDTH(WIDTH), .MULT_LATENCY(L)
    ) dut (
        .clk(clk), .rst(rst), .en(en), .req(req),
        .req_dataa(req_dataa), .req_datab(req_datab),
        .gnt(gnt), .rsp_valid(rsp_valid), .rsp_result(rsp_result),
        .array_mult_dataa(array_mult_dataa), .array_mult_datab(array_mult_datab),
        .array_mult_result(array_mult_result), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int            id;
        logic [LW-1:0] res;
        int            issue;
        int            due;
    } exp_t;

    exp_t                q[$];
    int                  n_tests = 0;
    int                  n_fail  = 0;
    int                  cyc     = 0;
    int                  mptr    = 0;
    bit                  mon_en  = 1'b0;
    logic [WIDTH-1:0]    da [NUM_REQ][LANES];
    logic [WIDTH-1:0]    db [NUM_REQ][LANES];
    logic [LW-1:0]       mpipe [L];

    function automatic logic [LW-1:0] lane_mul(input logic [LW-1:0] a, input logic [LW-1:0] b);
        logic [LW-1:0]      r;
        logic [2*WIDTH-1:0] p;
        r = '0;
        for (int l = 0; l < LANES; l++) begin
            p = {{WIDTH{1'b0}}, a[l*WIDTH +: WIDTH]} * {{WIDTH{1'b0}}, b[l*WIDTH +: WIDTH]};
            r[l*WIDTH +: WIDTH] = p[WIDTH-1:0];
        end
        return r;
    endfunction

    // Reference multiplier: product appears L cycles after the operands.
    always @(posedge clk) begin
        mpipe[0] <= lane_mul(array_mult_dataa, array_mult_datab);
        for (int s = 1; s < L; s++) mpipe[s] <= mpipe[s-1];
        cyc <= cyc + 1;
    end
    assign array_mult_result = mpipe[L-1];

    function automatic logic [WIDTH-1:0] rnd();
        logic [63:0] t;
        t = {$urandom(), $urandom()};
        return t[WIDTH-1:0];
    endfunction

    task automatic new_op(input int i);
        for (int l = 0; l < LANES; l++) begin
            da[i][l] = rnd();
            db[i][l] = rnd();
        end
    endtask

    function automatic logic [LW-1:0] flat(input int i, input bit sel_b);
        logic [LW-1:0] v;
        for (int l = 0; l < LANES; l++) v[l*WIDTH +: WIDTH] = sel_b ? db[i][l] : da[i][l];
        return v;
    endfunction

    task automatic step(input logic [NUM_REQ-1:0] r, input logic e, output int g);
        logic [NUM_REQ-1:0] eg;
        int                 idx;
        exp_t               x;
        @(negedge clk);
        req = r;
        en  = e;
        for (int i = 0; i < NUM_REQ; i++) begin
            req_dataa[i*LW +: LW] = flat(i, 1'b0);
            req_datab[i*LW +: LW] = flat(i, 1'b1);
        end
        #1;
        g = -1;
        if (e) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                idx = (mptr + k) % NUM_REQ;
                if (g < 0 && r[idx]) g = idx;
            end
        end
        eg = (g >= 0) ? (NUM_REQ'(1) << g) : '0;
        n_tests++;
        if (gnt !== eg) begin
            n_fail++;
            $display("FAIL gnt cyc=%0d got=%b expected=%b", cyc, gnt, eg);
        end
        if (g >= 0) begin
            x.id    = g;
            x.res   = lane_mul(flat(g, 1'b0), flat(g, 1'b1));
            x.issue = cyc;
            x.due   = cyc + 1 + L;
            q.push_back(x);
            mptr = (g + 1) % NUM_REQ;
            new_op(g);
        end
    endtask

    // Monitor: checks busy every cycle and each response against the scoreboard.
    initial begin
        exp_t x;
        bit   eb;
        forever begin
            @(negedge clk);
            #2;
            if (mon_en) begin
                eb = (q.size() > 0) && (q[0].issue < cyc);
                n_tests++;
                if (busy !== eb) begin
                    n_fail++;
                    $display("FAIL busy cyc=%0d got=%b expected=%b", cyc, busy, eb);
                end
                if (q.size() > 0 && q[0].due == cyc) begin
                    x = q.pop_front();
                    n_tests++;
                    if (rsp_valid !== (NUM_REQ'(1) << x.id) || rsp_result !== x.res) begin
                        n_fail++;
                        $display("FAIL rsp cyc=%0d got valid=%b res=%h expected valid=%b res=%h",
                                 cyc, rsp_valid, rsp_result, NUM_REQ'(1) << x.id, x.res);
                    end
                end else if (rsp_valid !== '0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL rsp_spurious cyc=%0d got valid=%b expected valid=0", cyc, rsp_valid);
                end
            end
        end
    end

    initial begin
        int                 g;
        logic [NUM_REQ-1:0] r;
        for (int i = 0; i < NUM_REQ; i++) new_op(i);
        for (int s = 0; s < L; s++) mpipe[s] = '0;
        repeat (3) @(negedge clk);
        rst    = 1'b1;
        mon_en = 1'b1;

        // Idle after reset
        repeat (20) step('0, 1'b1, g);
        n_tests++;
        if (array_mult_dataa !== '0 || array_mult_datab !== '0) begin
            n_fail++;
            $display("FAIL reset_operands got a=%h b=%h expected 0", array_mult_dataa, array_mult_datab);
        end

        // Single requester 2: 3*5 on lane 0
        for (int l = 0; l < LANES; l++) begin
            da[2][l] = '0;
            db[2][l] = '0;
        end
        da[2][0] = 36'd3;
        db[2][0] = 36'd5;
        step(6'b000100, 1'b1, g);
        repeat (L + 3) step('0, 1'b1, g);

        // All requesting, held
        repeat (12) step(6'b111111, 1'b1, g);
        repeat (L + 2) step('0, 1'b1, g);

        // Wrap: grant 4, then 5, then 0
        step(6'b010000, 1'b1, g);
        step(6'b100001, 1'b1, g);
        step(6'b100001, 1'b1, g);
        repeat (L + 2) step('0, 1'b1, g);

        // en falls with three ops in flight
        repeat (3) step(6'b111111, 1'b1, g);
        repeat (L + 4) step(6'b111111, 1'b0, g);

        // Lone requester granted every cycle
        repeat (5) step(6'b001000, 1'b1, g);
        repeat (L + 2) step('0, 1'b1, g);

        // Reset with two ops in flight; pointer left at 2 beforehand
        step(6'b000001, 1'b1, g);
        step(6'b000010, 1'b1, g);
        @(negedge clk);
        rst  = 1'b0;
        req  = '0;
        q.delete();
        mptr = 0;
        @(negedge clk);
        rst = 1'b1;
        repeat (L + 3) step('0, 1'b1, g);
        step(6'b111111, 1'b1, g);
        repeat (L + 2) step('0, 1'b1, g);

        // Randomized traffic; requests held until granted
        r = '0;
        for (int t = 0; t < 400; t++) begin
            r = r | NUM_REQ'($urandom() & $urandom());
            step(r, ($urandom_range(0, 7) != 0), g);
            if (g >= 0 && $urandom_range(0, 1) == 0) r[g] = 1'b0;
        end
        repeat (L + 4) step('0, 1'b1, g);

        n_tests++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL drain got %0d outstanding expected 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
